collision_player_multi: RTL and testbench
=========================================

Name: collision_player_multi

Overview:
- Generalised player-vs-object collision detector for the VGA pipeline.
- Compares the player drawing request against N_OBJ independent object drawing requests every pixel clock.
- Produces one registered hit pulse per object channel per frame, plus a priority-encoded hit index and an end-of-frame summary of which objects were hit.
- Sits beside the drawing muxes; its outputs feed game logic (score, pickup removal, sound).

Parameters:
- N_OBJ, 8, number of object channels (1..32).
- CNT_W, $clog2(N_OBJ+1), width of the per-frame hit count.
- MIN_PIXELS, 4, overlap pixels required per channel per frame before a hit is declared. Used only with COLLISION_THRESHOLD_EN; range 1..255.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset
- startOfFrame  in  1  one-cycle frame-start strobe
- playerDrawingRequest  in  1  player pixel active
- objDrawingRequest  in  N_OBJ  per-object pixel active
- objEnable  in  N_OBJ  channel enable; a 0 masks that channel completely
- hitPulse  out  N_OBJ  one-cycle pulse per channel, first hit in frame
- hitValid  out  1  OR of hitPulse
- hitIndex  out  $clog2(N_OBJ) (min 1)  lowest set bit of hitPulse; 0 when hitValid=0
- frameHitMask  out  N_OBJ  channels hit during the previous frame
- frameHitCount  out  CNT_W  popcount of frameHitMask
- frameDone  out  1  one-cycle pulse when frameHitMask/frameHitCount update

Behaviour:
- Reset is asynchronous and active-low on resetN; clock is clk. All outputs and internal state reset to 0.
- collision[i] = playerDrawingRequest & objDrawingRequest[i] & objEnable[i].
- Per channel there is a sticky flag[i] (hit already reported this frame) and a curMask[i] (accumulating the current frame's hits).
- Default mode (macro undefined):
  - A cycle with collision[i]=1 and flag[i]=0 sets flag[i] and curMask[i].
  - hitPulse[i] is high in the following cycle only (registered, latency 1, width 1).
- hitValid and hitIndex are registered in the same cycle as hitPulse and derived from the same next-state vector.
  - Several channels may pulse together; hitIndex reports the lowest index.
- On startOfFrame:
  - frameHitMask <= curMask and frameHitCount <= popcount(curMask).
  - frameDone pulses in the next cycle, aligned with the updated values.
  - All flags and curMask clear.
- startOfFrame and collision[i] in the same cycle:
  - The collision belongs to the new frame. flag[i] and curMask[i] are set (set wins over clear) and hitPulse[i] fires.
  - That hit is excluded from the frameHitMask being published in that cycle.
- objEnable[i] falling mid-frame: no further hits on channel i. The already-set flag/curMask bits are retained until the next startOfFrame.
- With no startOfFrame, flags stay set indefinitely; no channel re-fires.
- frameHitCount never overflows, since CNT_W covers N_OBJ.
- The reset condition dominates all other inputs.

Optional Feature:
- Macro: COLLISION_THRESHOLD_EN.
- Defined:
  - Each channel gets a saturating overlap counter of $clog2(MIN_PIXELS+1) bits, cleared on startOfFrame.
  - The counter increments on each collision[i] cycle.
  - A hit is declared on the cycle of the MIN_PIXELS-th overlap pixel in the frame. hitPulse follows 1 cycle later; all other rules are unchanged.
  - A startOfFrame coinciding with a collision restarts the counter at 1.
  - With MIN_PIXELS=1 the behaviour is identical to the undefined case.
- Undefined: no counters are synthesised; the first overlap pixel declares the hit.

Decomposition:
- Package collision_pkg:
  - constant MAX_OBJ=32
  - typedef obj_mask_t (logic [MAX_OBJ-1:0])
  - function popcount
  - function lowest_set_index
- Sub-module collision_channel: one instance per object, generate-looped. Contains flag, curMask bit and the optional threshold counter; outputs hitNext and curMask.
- The top level holds the priority encoder, the registered outputs and the frame summary registers.

Test Plan:
- Reset mid-frame with flags set (N_OBJ=8) → all outputs 0; a subsequent collision on ch2 → hitPulse=8'h04, hitIndex=2, hitValid=1 for exactly 1 cycle.
- Player overlaps ch5 for 10 consecutive cycles → a single hitPulse[5]. Next startOfFrame → frameDone=1, frameHitMask=8'h20, frameHitCount=1.
- Same-cycle collision on ch1 and ch6 → hitPulse=8'h42, hitIndex=1. Frame summary count=2.
- startOfFrame coincident with a ch3 collision → frameHitMask excludes bit 3 and hitPulse[3] fires. The following frame's summary has bit 3 set.
- objEnable[4]=0 with continuous overlap on ch4 → no pulse and frameHitMask[4]=0. Re-enable mid-frame → pulse fires on the next overlap.
- With COLLISION_THRESHOLD_EN and MIN_PIXELS=4:
  - Overlaps of 3 pixels, gap, then 1 pixel on ch0 → hitPulse[0] 1 cycle after the 4th overlap.
  - 3 pixels, then startOfFrame, then 3 pixels → no hit.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared constants and helpers for the player-vs-object collision detector.
// Masks are carried at MAX_OBJ width so the helpers serve any channel count.
package collision_pkg;

    localparam int MAX_OBJ = 32;

    typedef logic [MAX_OBJ-1:0] obj_mask_t;

    function automatic logic [5:0] popcount(input obj_mask_t m);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MAX_OBJ; i++) begin
            c = c + {5'd0, m[i]};
        end
        return c;
    endfunction

    // Scans from the top so that the last assignment is the lowest set bit.
    function automatic logic [4:0] lowest_set_index(input obj_mask_t m);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_OBJ - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/collision_channel.sv
// One object channel: sticky per-frame hit flag, current-frame mask bit and,
// when COLLISION_THRESHOLD_EN is defined, a saturating overlap-pixel counter.
module collision_channel
    import collision_pkg::*;
#(
    parameter int MIN_PIXELS = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic collision,
    output logic hitNext,
    output logic curMask
);

    logic r_flag;
    logic r_cur_mask;
    logic w_flag_base;
    logic w_hit_next;

    // A frame start clears state, but a coincident collision re-sets it below.
    assign w_flag_base = startOfFrame ? 1'b0 : r_flag;

`ifdef COLLISION_THRESHOLD_EN
    localparam int CW = $clog2(MIN_PIXELS + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MIN_PIXELS);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_base;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_base = startOfFrame ? '0 : r_cnt;
        w_cnt_next = w_cnt_base;
        if (collision && (w_cnt_base != LIMIT)) begin
            w_cnt_next = w_cnt_base + CW'(1);
        end
        w_hit_next = collision & ~w_flag_base & (w_cnt_next == LIMIT);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    assign w_hit_next = collision & ~w_flag_base;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_flag     <= 1'b0;
            r_cur_mask <= 1'b0;
        end else begin
            r_flag     <= w_flag_base | w_hit_next;
            r_cur_mask <= (startOfFrame ? 1'b0 : r_cur_mask) | w_hit_next;
        end
    end

    assign hitNext = w_hit_next;
    assign curMask = r_cur_mask;

endmodule

// File: rtl/collision_player_multi.sv
// Player-vs-N-object collision detector: per-channel first-hit pulses, priority
// index and end-of-frame summary. Optional overlap threshold: COLLISION_THRESHOLD_EN.
module collision_player_multi
    import collision_pkg::*;
#(
    parameter int N_OBJ      = 8,
    parameter int CNT_W      = $clog2(N_OBJ + 1),
    parameter int MIN_PIXELS = 4
) (
    input  logic                                     clk,
    input  logic                                     resetN,
    input  logic                                     startOfFrame,
    input  logic                                     playerDrawingRequest,
    input  logic [N_OBJ-1:0]                         objDrawingRequest,
    input  logic [N_OBJ-1:0]                         objEnable,
    output logic [N_OBJ-1:0]                         hitPulse,
    output logic                                     hitValid,
    output logic [((N_OBJ > 1) ? $clog2(N_OBJ) : 1)-1:0] hitIndex,
    output logic [N_OBJ-1:0]                         frameHitMask,
    output logic [CNT_W-1:0]                         frameHitCount,
    output logic                                     frameDone
);

    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    logic [N_OBJ-1:0] w_collision;
    logic [N_OBJ-1:0] w_hit_next;
    logic [N_OBJ-1:0] w_cur_mask;
    obj_mask_t        w_hit_pad;
    obj_mask_t        w_cur_pad;

    logic [N_OBJ-1:0] r_hit_pulse;
    logic             r_hit_valid;
    logic [IDX_W-1:0] r_hit_index;
    logic [N_OBJ-1:0] r_frame_mask;
    logic [CNT_W-1:0] r_frame_count;
    logic             r_frame_done;

    assign w_collision = {N_OBJ{playerDrawingRequest}} & objDrawingRequest & objEnable;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_ch
        collision_channel #(
            .MIN_PIXELS (MIN_PIXELS)
        ) u_ch (
            .clk          (clk),
            .resetN       (resetN),
            .startOfFrame (startOfFrame),
            .collision    (w_collision[g]),
            .hitNext      (w_hit_next[g]),
            .curMask      (w_cur_mask[g])
        );
    end

    always_comb begin
        w_hit_pad = '0;
        w_cur_pad = '0;
        w_hit_pad[N_OBJ-1:0] = w_hit_next;
        w_cur_pad[N_OBJ-1:0] = w_cur_mask;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hit_pulse <= '0;
            r_hit_valid <= 1'b0;
            r_hit_index <= '0;
        end else begin
            r_hit_pulse <= w_hit_next;
            r_hit_valid <= |w_hit_next;
            r_hit_index <= IDX_W'(lowest_set_index(w_hit_pad));
        end
    end

    // w_cur_mask is still the closing frame's mask, so a coincident hit is excluded.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame_mask  <= '0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= startOfFrame;
            if (startOfFrame) begin
                r_frame_mask  <= w_cur_mask;
                r_frame_count <= CNT_W'(popcount(w_cur_pad));
            end
        end
    end

    assign hitPulse      = r_hit_pulse;
    assign hitValid      = r_hit_valid;
    assign hitIndex      = r_hit_index;
    assign frameHitMask  = r_frame_mask;
    assign frameHitCount = r_frame_count;
    assign frameDone     = r_frame_done;

endmodule

// File: tb/tb_collision_player_multi.sv
// Directed bench for collision_player_multi (N_OBJ=8); expected per-cycle outputs
// are queued when a step is driven and popped after the clock edge.
module tb_collision_player_multi;

    localparam int W = 21;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       playerDrawingRequest;
    logic [7:0] objDrawingRequest;
    logic [7:0] objEnable;
    logic [7:0] hitPulse;
    logic       hitValid;
    logic [2:0] hitIndex;
    logic [7:0] frameHitMask;
    logic [3:0] frameHitCount;
    logic       frameDone;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   held_mask;
    logic [3:0]   held_cnt;

    collision_player_multi dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .playerDrawingRequest (playerDrawingRequest),
        .objDrawingRequest    (objDrawingRequest),
        .objEnable            (objEnable),
        .hitPulse             (hitPulse),
        .hitValid             (hitValid),
        .hitIndex             (hitIndex),
        .frameHitMask         (frameHitMask),
        .frameHitCount        (frameHitCount),
        .frameDone            (frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] low_idx(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_pulse"}, 32'(hitPulse), 32'h0);
        chk({tag, "_valid"}, 32'(hitValid), 32'h0);
        chk({tag, "_index"}, 32'(hitIndex), 32'h0);
        chk({tag, "_mask"},  32'(frameHitMask), 32'h0);
        chk({tag, "_count"}, 32'(frameHitCount), 32'h0);
        chk({tag, "_done"},  32'(frameDone), 32'h0);
    endtask

    // One pixel cycle; sum_mask/sum_cnt are the summary published when sof=1.
    task automatic step(input string tag, input logic pl, input logic [7:0] obj, input logic sof,
                        input logic [7:0] exp_pulse, input logic [7:0] sum_mask = 8'h00,
                        input logic [3:0] sum_cnt = 4'd0);
        logic [W-1:0] e;
        playerDrawingRequest = pl;
        objDrawingRequest    = obj;
        startOfFrame         = sof;
        if (sof) begin
            held_mask = sum_mask;
            held_cnt  = sum_cnt;
        end
        exp_q.push_back({exp_pulse, sof, held_mask, held_cnt});
        @(posedge clk);
        #1;
        playerDrawingRequest = 1'b0;
        objDrawingRequest    = 8'h00;
        startOfFrame         = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "_pulse"}, 32'(hitPulse), 32'(e[20:13]));
        chk({tag, "_valid"}, 32'(hitValid), 32'(|e[20:13]));
        chk({tag, "_index"}, 32'(hitIndex), 32'(low_idx(e[20:13])));
        chk({tag, "_done"},  32'(frameDone), 32'(e[12]));
        chk({tag, "_mask"},  32'(frameHitMask), 32'(e[11:4]));
        chk({tag, "_count"}, 32'(frameHitCount), 32'(e[3:0]));
    endtask

    initial begin
        resetN               = 1'b0;
        startOfFrame         = 1'b0;
        playerDrawingRequest = 1'b0;
        objDrawingRequest    = 8'h00;
        objEnable            = 8'hFF;
        held_mask            = 8'h00;
        held_cnt             = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        resetN = 1'b1;

`ifdef COLLISION_THRESHOLD_EN
        // 3 overlap pixels, a gap, then the 4th pixel declares the hit.
        for (int i = 0; i < 3; i++) step("th_pre", 1'b1, 8'h01, 1'b0, 8'h00);
        step("th_gap", 1'b0, 8'h00, 1'b0, 8'h00);
        step("th_4th", 1'b1, 8'h01, 1'b0, 8'h01);
        step("th_more", 1'b1, 8'h01, 1'b0, 8'h00);
        step("th_sof1", 1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 4'd1);
        // 3 pixels, frame start, 3 pixels: counter restarts, never reaches 4.
        for (int i = 0; i < 3; i++) step("th_a", 1'b1, 8'h02, 1'b0, 8'h00);
        step("th_sof2", 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 4'd0);
        for (int i = 0; i < 3; i++) step("th_b", 1'b1, 8'h02, 1'b0, 8'h00);
        step("th_sof3", 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 4'd0);
        // Coincident frame start counts as pixel 1 of the new frame.
        for (int i = 0; i < 3; i++) step("th_c", 1'b1, 8'h04, 1'b0, 8'h00);
        step("th_sof4", 1'b1, 8'h04, 1'b1, 8'h00, 8'h00, 4'd0);
        for (int i = 0; i < 2; i++) step("th_d", 1'b1, 8'h04, 1'b0, 8'h00);
        step("th_hit", 1'b1, 8'h04, 1'b0, 8'h04);
        step("th_sof5", 1'b0, 8'h00, 1'b1, 8'h00, 8'h04, 4'd1);
`else
        // Reset mid-frame with flags set and a summary held.
        step("pre_hit", 1'b1, 8'h02, 1'b0, 8'h02);
        step("pre_sof", 1'b1, 8'h01, 1'b1, 8'h01, 8'h02, 4'd1);
        resetN = 1'b0;
        #1;
        check_all_zero("midreset");
        held_mask = 8'h00;
        held_cnt  = 4'd0;
        @(negedge clk);
        resetN = 1'b1;
        step("ch0_again", 1'b1, 8'h01, 1'b0, 8'h01);
        step("ch2_hit", 1'b1, 8'h04, 1'b0, 8'h04);
        step("ch2_once", 1'b0, 8'h00, 1'b0, 8'h00);
        step("sof_a", 1'b0, 8'h00, 1'b1, 8'h00, 8'h05, 4'd2);
        step("done_low", 1'b0, 8'h00, 1'b0, 8'h00);

        // Long overlap on ch5 gives one pulse.
        step("ch5_first", 1'b1, 8'h20, 1'b0, 8'h20);
        for (int i = 0; i < 9; i++) step("ch5_hold", 1'b1, 8'h20, 1'b0, 8'h00);
        step("sof_ch5", 1'b0, 8'h00, 1'b1, 8'h00, 8'h20, 4'd1);

        // Simultaneous hits; object without player is not a hit.
        step("no_player", 1'b0, 8'h80, 1'b0, 8'h00);
        step("ch1_ch6", 1'b1, 8'h42, 1'b0, 8'h42);
        step("sof_two", 1'b0, 8'h00, 1'b1, 8'h00, 8'h42, 4'd2);

        // Hit coincident with frame start belongs to the new frame.
        step("ch0_pre", 1'b1, 8'h01, 1'b0, 8'h01);
        step("sof_ch3", 1'b1, 8'h08, 1'b1, 8'h08, 8'h01, 4'd1);
        step("ch3_noref", 1'b1, 8'h08, 1'b0, 8'h00);
        step("sof_after3", 1'b0, 8'h00, 1'b1, 8'h00, 8'h08, 4'd1);

        // Disabled channel is masked; re-enable lets it fire.
        objEnable = 8'hEF;
        for (int i = 0; i < 3; i++) step("ch4_off", 1'b1, 8'h10, 1'b0, 8'h00);
        step("sof_off", 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 4'd0);
        step("ch4_off2", 1'b1, 8'h10, 1'b0, 8'h00);
        objEnable = 8'hFF;
        step("ch4_on", 1'b1, 8'h10, 1'b0, 8'h10);
        step("sof_on", 1'b0, 8'h00, 1'b1, 8'h00, 8'h10, 4'd1);

        // Disabling after a hit retains the frame bit.
        step("ch6_hit", 1'b1, 8'h40, 1'b0, 8'h40);
        objEnable = 8'hBF;
        step("ch6_off", 1'b1, 8'h40, 1'b0, 8'h00);
        step("sof_keep", 1'b0, 8'h00, 1'b1, 8'h00, 8'h40, 4'd1);
        objEnable = 8'hFF;

        // Random single-channel frames.
        for (int k = 0; k < 4; k++) begin
            logic [7:0] m;
            m = 8'h01 << $urandom_range(0, 7);
            step("rnd_hit", 1'b1, m, 1'b0, m);
            step("rnd_hold", 1'b1, m, 1'b0, 8'h00);
            step("rnd_sof", 1'b0, 8'h00, 1'b1, 8'h00, m, 4'd1);
        end
        step("empty_sof", 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 4'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
